alarm_time_counter: RTL and testbench
=====================================

Name: alarm_time_counter

Overview:
- Parametrised time-of-day counter with its own 1 Hz prescaler, 12/24-hour display mode, seconds output, and a single-alarm controller with snooze and auto-timeout.
- Successor to the basic HOURS/MINS/SECS pulse-driven time counter.
- Sits between the system clock and the display/buzzer drivers.
- Internal time is always held as 24-hour hh:mm:ss.

Parameters:
TICKS_PER_SEC, 1000, clk cycles per second (>=1); prescaler width is $clog2 of this value, minimum 1
SNOOZE_MIN, 5, snooze length in minutes (>=1)
RING_TIMEOUT_SEC, 60, seconds of ringing before auto-stop (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
run  in  1  1 = prescaler and timekeeping advance; 0 = frozen
mode_24h  in  1  1 = 24-hour display; 0 = 12-hour display
set_alarm  in  1  1 = increments and display target the alarm; 0 = target the time
inc_hour  in  1  per-cycle hour increment request
inc_min  in  1  per-cycle minute increment request
alarm_en  in  1  alarm armed
snooze  in  1  snooze request, level sampled each cycle
stop  in  1  stop request, level sampled each cycle
hours_out  out  5  displayed hours
minutes_out  out  6  displayed minutes
seconds_out  out  6  displayed seconds
pm_out  out  1  PM indicator
ringing  out  1  alarm sounding
sec_tick  out  1  one-cycle pulse per advanced second

Behaviour:
Reset (asynchronous, takes effect immediately):
- Time 00:00:00, alarm 00:00, prescaler 0, FSM IDLE, ringing=0, sec_tick=0.
- Displayed values follow the decode rules: 12h mode shows hours_out=12, pm_out=0; 24h mode shows 0.
- Reset mid-ring drops ringing at once.

Prescaler:
- Counts 0..TICKS_PER_SEC-1 while run=1; holds its value while run=0.
- A tick occurs on the edge where the count wraps to 0.

Tick:
- Seconds increment; 59->0 carries into minutes; minutes 59->0 carries into hours; hours 23->0.
- sec_tick is registered and is high for exactly the one cycle in which the new seconds value is visible.

Manual set (one step per cycle per asserted input):
- Target is the time when set_alarm=0, the alarm when set_alarm=1.
- inc_hour: hour+1 mod 24, no carry.
- inc_min: minute+1 mod 60, no carry into hour.
- inc_min on the time also clears seconds and the prescaler.
- If a tick and a time increment land in the same cycle, the tick (with its carries) is applied first, then the increment. Example: 10:59:59 with tick and inc_min -> 11:01:00.
- inc_hour and inc_min together both apply.
- Alarm edits never touch the time; the time keeps running while the alarm is edited.

Display decode (combinational from registers, no extra latency):
- Source is the alarm when set_alarm=1, with seconds_out=0; otherwise the time.
- 24h mode: hours_out=hour, pm_out=0.
- 12h mode: hour 0 -> 12 AM; 1-11 -> same, AM; 12 -> 12 PM; 13-23 -> hour-12, PM.
- pm_out=1 means PM.

Alarm FSM (states IDLE, RINGING, SNOOZE):
- Match event: a tick whose resulting time equals alarm hh:mm:00 while alarm_en=1. Manual edits never create a match.
- IDLE -> RINGING on a match event. Ringing starts on the same edge the time becomes hh:mm:00, and the ring counter is cleared.
- RINGING:
  - stop -> IDLE.
  - else snooze -> SNOOZE, loading SNOOZE_MIN*60 seconds.
  - else after RING_TIMEOUT_SEC ticks -> IDLE.
- SNOOZE:
  - stop -> IDLE.
  - Counter decrements on each tick; on reaching 0 -> RINGING with the ring counter cleared.
  - snooze input is ignored.
- stop and snooze in the same cycle: stop wins.
- alarm_en=0 forces IDLE from any state on the next edge.
- Match events in RINGING or SNOOZE are ignored.
- run=0 freezes both the ring and snooze counters; stop still works.
- ringing=1 exactly while the state is RINGING (registered).

Test Plan:
- TICKS_PER_SEC=4, run=1, 12h mode, after reset: hours_out=12, pm_out=0; sec_tick pulses every 4 clocks and seconds_out reaches 1 after the first pulse.
- Set time to 11:59:59, one tick -> 12:00:00, pm_out=1. Set time to 23:59:59, one tick -> 00:00:00, display 12 AM; in 24h mode display 0.
- Time 10:59:30, inc_min -> 10:00:00 with prescaler cleared; inc_hour at 23:xx -> 00:xx; inc_min coinciding with a tick at 10:59:59 -> 11:01:00.
- Alarm 07:30, alarm_en=1, time 07:29:59, tick -> ringing=1 on the same edge minutes_out=30; stop -> ringing=0 next edge.
- SNOOZE_MIN=1, RING_TIMEOUT_SEC=3: snooze while ringing -> ringing=0; after 60 ticks ringing=1; no stop -> ringing=0 after 3 further ticks.
- Negative cases:
  - stop and snooze together -> IDLE.
  - alarm_en dropped during SNOOZE -> never rings.
  - run=0 for 100 clocks -> time and counters unchanged.
  - reset_n low mid-ring -> ringing=0 before the next clk edge.

Source files
------------

// File: rtl/alarm_time_counter.sv
// Time-of-day counter with built-in 1 Hz prescaler, 12/24-hour display decode
// and a single alarm with snooze and ring timeout. Time is held as 24-hour hh:mm:ss.
module alarm_time_counter #(
  parameter int TICKS_PER_SEC    = 1000,
  parameter int SNOOZE_MIN       = 5,
  parameter int RING_TIMEOUT_SEC = 60
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       run,
  input  logic       mode_24h,
  input  logic       set_alarm,
  input  logic       inc_hour,
  input  logic       inc_min,
  input  logic       alarm_en,
  input  logic       snooze,
  input  logic       stop,
  output logic [4:0] hours_out,
  output logic [5:0] minutes_out,
  output logic [5:0] seconds_out,
  output logic       pm_out,
  output logic       ringing,
  output logic       sec_tick
);

  localparam int PW         = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int SNOOZE_SEC = SNOOZE_MIN * 60;
  localparam int SW         = $clog2(SNOOZE_SEC + 1);
  localparam int RW         = (RING_TIMEOUT_SEC > 1) ? $clog2(RING_TIMEOUT_SEC) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);
  localparam logic [SW-1:0] SNOOZE_LOAD = SW'(SNOOZE_SEC);
  localparam logic [RW-1:0] RING_LAST = RW'(RING_TIMEOUT_SEC - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RINGING, ST_SNOOZE} state_t;

  logic [PW-1:0] r_presc;
  logic [4:0]    r_hour, r_al_hour;
  logic [5:0]    r_min, r_sec, r_al_min;
  logic          r_sec_tick;
  state_t        r_state;
  logic [RW-1:0] r_ring_cnt;
  logic [SW-1:0] r_snooze_cnt;

  logic          w_tick, w_time_inc_min, w_time_inc_hour, w_match;
  logic [4:0]    w_hour_t, w_hour_n;
  logic [5:0]    w_min_t, w_min_n, w_sec_t, w_sec_n;
  state_t        w_state_n;
  logic [RW-1:0] w_ring_cnt_n;
  logic [SW-1:0] w_snooze_cnt_n;
  logic [4:0]    w_src_hour;

  assign w_tick          = run && (r_presc == PRESC_MAX);
  assign w_time_inc_min  = inc_min && !set_alarm;
  assign w_time_inc_hour = inc_hour && !set_alarm;

  // Tick with carries first, then manual edits on top of the ticked value.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_sec_t  = r_sec;
    w_min_t  = r_min;
    w_hour_t = r_hour;
    if (w_tick) begin
      if (r_sec == 6'd59) begin
        w_sec_t = '0;
        if (r_min == 6'd59) begin
          w_min_t  = '0;
          w_hour_t = (r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1;
        end else begin
          w_min_t = r_min + 6'd1;
        end
      end else begin
        w_sec_t = r_sec + 6'd1;
      end
    end
    w_match  = w_tick && alarm_en && (w_hour_t == r_al_hour) &&
               (w_min_t == r_al_min) && (w_sec_t == 6'd0);
    w_sec_n  = w_time_inc_min ? 6'd0 : w_sec_t;
    w_min_n  = w_min_t;
    w_hour_n = w_hour_t;
    if (w_time_inc_min)
      w_min_n = (w_min_t == 6'd59) ? 6'd0 : w_min_t + 6'd1;
    if (w_time_inc_hour)
      w_hour_n = (w_hour_t == 5'd23) ? 5'd0 : w_hour_t + 5'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc    <= '0;
      r_hour     <= '0;
      r_min      <= '0;
      r_sec      <= '0;
      r_al_hour  <= '0;
      r_al_min   <= '0;
      r_sec_tick <= 1'b0;
    end else begin
      r_sec_tick <= w_tick;
      r_hour     <= w_hour_n;
      r_min      <= w_min_n;
      r_sec      <= w_sec_n;
      if (w_time_inc_min)
        r_presc <= '0;
      else if (run)
        r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (set_alarm && inc_hour)
        r_al_hour <= (r_al_hour == 5'd23) ? 5'd0 : r_al_hour + 5'd1;
      if (set_alarm && inc_min)
        r_al_min <= (r_al_min == 6'd59) ? 6'd0 : r_al_min + 6'd1;
    end
  end

  // Alarm FSM: counters only move on ticks, so run=0 freezes them.
  always_comb begin
    w_state_n      = r_state;
    w_ring_cnt_n   = r_ring_cnt;
    w_snooze_cnt_n = r_snooze_cnt;
    if (!alarm_en) begin
      w_state_n = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: if (w_match) begin
          w_state_n    = ST_RINGING;
          w_ring_cnt_n = '0;
        end
        ST_RINGING: begin
          if (stop) begin
            w_state_n = ST_IDLE;
          end else if (snooze) begin
            w_state_n      = ST_SNOOZE;
            w_snooze_cnt_n = SNOOZE_LOAD;
          end else if (w_tick) begin
            if (r_ring_cnt == RING_LAST) w_state_n = ST_IDLE;
            else                         w_ring_cnt_n = r_ring_cnt + 1'b1;
          end
        end
        ST_SNOOZE: begin
          if (stop) begin
            w_state_n = ST_IDLE;
          end else if (w_tick) begin
            w_snooze_cnt_n = r_snooze_cnt - 1'b1;
            if (r_snooze_cnt <= SW'(1)) begin
              w_state_n      = ST_RINGING;
              w_ring_cnt_n   = '0;
              w_snooze_cnt_n = '0;
            end
          end
        end
        default: w_state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_ring_cnt   <= '0;
      r_snooze_cnt <= '0;
    end else begin
      r_state      <= w_state_n;
      r_ring_cnt   <= w_ring_cnt_n;
      r_snooze_cnt <= w_snooze_cnt_n;
    end
  end

  assign ringing  = (r_state == ST_RINGING);
  assign sec_tick = r_sec_tick;

  always_comb begin
    w_src_hour  = set_alarm ? r_al_hour : r_hour;
    minutes_out = set_alarm ? r_al_min : r_min;
    seconds_out = set_alarm ? 6'd0 : r_sec;
    hours_out   = w_src_hour;
    pm_out      = 1'b0;
    if (!mode_24h) begin
      if (w_src_hour == 5'd0) begin
        hours_out = 5'd12;
      end else if (w_src_hour >= 5'd12) begin
        pm_out = 1'b1;
        if (w_src_hour > 5'd12) hours_out = w_src_hour - 5'd12;
      end
    end
  end

endmodule

// File: tb/tb_alarm_time_counter.sv
// Directed bench for alarm_time_counter: decode table plus hand-timed
// sequences for ticks, carries, manual set and the alarm/snooze/timeout FSM.
module tb_alarm_time_counter;

  logic       clk = 1'b0;
  logic       reset_n, run, mode_24h, set_alarm, inc_hour, inc_min;
  logic       alarm_en, snooze, stop;
  logic [4:0] hours_out;
  logic [5:0] minutes_out, seconds_out;
  logic       pm_out, ringing, sec_tick;

  int checks = 0;
  int errors = 0;

  alarm_time_counter #(
    .TICKS_PER_SEC(4), .SNOOZE_MIN(1), .RING_TIMEOUT_SEC(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .mode_24h(mode_24h),
    .set_alarm(set_alarm), .inc_hour(inc_hour), .inc_min(inc_min),
    .alarm_en(alarm_en), .snooze(snooze), .stop(stop),
    .hours_out(hours_out), .minutes_out(minutes_out), .seconds_out(seconds_out),
    .pm_out(pm_out), .ringing(ringing), .sec_tick(sec_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         n_inc;
    logic       mode;
    logic [4:0] exp_hours;
    logic       exp_pm;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs change right after a falling edge and are sampled at the next one.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reset, then reach h:m:s in 24h mode; leaves run=0 and prescaler at 0.
  task automatic reset_to(input int h, input int m, input int s);
    run = 0; set_alarm = 0; inc_hour = 0; inc_min = 0;
    alarm_en = 0; snooze = 0; stop = 0; mode_24h = 1;
    reset_n = 0;
    step();
    reset_n = 1;
    inc_hour = 1; steps(h); inc_hour = 0;
    inc_min = 1;  steps(m); inc_min = 0;
    run = 1; steps(s * 4); run = 0;
  endtask

  task automatic set_alarm_to(input int h, input int m);
    set_alarm = 1;
    inc_hour = 1; steps(h); inc_hour = 0;
    inc_min = 1;  steps(m); inc_min = 0;
    set_alarm = 0;
  endtask

  // Time 07:29:59, alarm 07:30 armed; returns right after the ringing edge.
  task automatic ring_up();
    reset_to(7, 29, 59);
    set_alarm_to(7, 30);
    alarm_en = 1;
    run = 1;
    steps(3);
    check("pre_ring", ringing, 0);
    step();
    check("ring_start", ringing, 1);
    check("ring_start_min", minutes_out, 30);
    check("ring_start_sec", seconds_out, 0);
  endtask

  initial begin
    vecs[0]  = '{0,  1'b0, 5'd12, 1'b0};
    vecs[1]  = '{0,  1'b1, 5'd0,  1'b0};
    vecs[2]  = '{1,  1'b0, 5'd1,  1'b0};
    vecs[3]  = '{10, 1'b0, 5'd11, 1'b0};
    vecs[4]  = '{1,  1'b0, 5'd12, 1'b1};
    vecs[5]  = '{0,  1'b1, 5'd12, 1'b0};
    vecs[6]  = '{1,  1'b0, 5'd1,  1'b1};
    vecs[7]  = '{10, 1'b0, 5'd11, 1'b1};
    vecs[8]  = '{0,  1'b1, 5'd23, 1'b0};
    vecs[9]  = '{1,  1'b0, 5'd12, 1'b0};
    vecs[10] = '{1,  1'b1, 5'd1,  1'b0};

    // Reset state and first ticks, 12h mode, run=1.
    reset_n = 0; run = 1; mode_24h = 0; set_alarm = 0; inc_hour = 0;
    inc_min = 0; alarm_en = 0; snooze = 0; stop = 0;
    step();
    check("rst_hours_12h", hours_out, 12);
    check("rst_pm", pm_out, 0);
    check("rst_min", minutes_out, 0);
    check("rst_sec", seconds_out, 0);
    check("rst_ringing", ringing, 0);
    check("rst_sec_tick", sec_tick, 0);
    mode_24h = 1; #1;
    check("rst_hours_24h", hours_out, 0);
    mode_24h = 0;
    step();
    reset_n = 1;
    steps(3);
    check("tick1_early_sec", seconds_out, 0);
    check("tick1_early_pulse", sec_tick, 0);
    step();
    check("tick1_sec", seconds_out, 1);
    check("tick1_pulse", sec_tick, 1);
    step();
    check("tick1_pulse_low", sec_tick, 0);
    steps(3);
    check("tick2_sec", seconds_out, 2);
    check("tick2_pulse", sec_tick, 1);

    // Display decode table on the alarm hour; time must stay untouched.
    reset_to(0, 0, 0);
    set_alarm = 1;
    for (int i = 0; i < 11; i++) begin
      inc_hour = 1; steps(vecs[i].n_inc); inc_hour = 0;
      mode_24h = vecs[i].mode; #1;
      check($sformatf("dec%0d_hours", i), hours_out, vecs[i].exp_hours);
      check($sformatf("dec%0d_pm", i), pm_out, vecs[i].exp_pm);
      check($sformatf("dec%0d_sec", i), seconds_out, 0);
    end
    set_alarm = 0; mode_24h = 1; #1;
    check("alarm_edit_time_hour", hours_out, 0);
    check("alarm_edit_time_min", minutes_out, 0);

    // 11:59:59 -> 12:00:00 PM
    reset_to(11, 59, 59);
    mode_24h = 0; #1;
    check("pre_noon_hours", hours_out, 11);
    check("pre_noon_sec", seconds_out, 59);
    run = 1; steps(4); run = 0;
    check("noon_hours", hours_out, 12);
    check("noon_min", minutes_out, 0);
    check("noon_sec", seconds_out, 0);
    check("noon_pm", pm_out, 1);

    // 23:59:59 -> midnight
    reset_to(23, 59, 59);
    mode_24h = 0;
    run = 1; steps(4); run = 0;
    check("midnight_hours_12h", hours_out, 12);
    check("midnight_pm", pm_out, 0);
    check("midnight_min", minutes_out, 0);
    mode_24h = 1; #1;
    check("midnight_hours_24h", hours_out, 0);

    // inc_min clears seconds and prescaler: 10:59:30 -> 10:00:00
    reset_to(10, 59, 30);
    run = 1; steps(2);
    inc_min = 1; step(); inc_min = 0;
    check("incmin_hours", hours_out, 10);
    check("incmin_min", minutes_out, 0);
    check("incmin_sec", seconds_out, 0);
    steps(3);
    check("incmin_presc_early", seconds_out, 0);
    step();
    check("incmin_presc_tick", seconds_out, 1);
    run = 0;

    // inc_hour wraps 23 -> 0 without carry
    reset_to(23, 15, 0);
    inc_hour = 1; step(); inc_hour = 0;
    check("inchour_wrap", hours_out, 0);
    check("inchour_min", minutes_out, 15);

    // tick and inc_min together: 10:59:59 -> 11:01:00
    reset_to(10, 59, 59);
    run = 1; steps(3);
    inc_min = 1; step(); inc_min = 0; run = 0;
    check("coinc_hours", hours_out, 11);
    check("coinc_min", minutes_out, 1);
    check("coinc_sec", seconds_out, 0);

    // both increments together
    reset_to(5, 10, 0);
    inc_hour = 1; inc_min = 1; step(); inc_hour = 0; inc_min = 0;
    check("both_hours", hours_out, 6);
    check("both_min", minutes_out, 11);

    // Ring, alarm display while ringing, stop with run=0
    ring_up();
    set_alarm = 1; #1;
    check("alarm_disp_hours", hours_out, 7);
    check("alarm_disp_min", minutes_out, 30);
    check("alarm_disp_sec", seconds_out, 0);
    set_alarm = 0;
    run = 0;
    stop = 1; step(); stop = 0;
    check("stop_ringing", ringing, 0);

    // Snooze with a frozen stretch, re-ring, then timeout with a frozen stretch
    ring_up();
    snooze = 1; step(); snooze = 0;
    check("snooze_ringing", ringing, 0);
    run = 0; steps(100);
    check("freeze_min", minutes_out, 30);
    check("freeze_sec", seconds_out, 0);
    check("freeze_pulse", sec_tick, 0);
    check("freeze_ringing", ringing, 0);
    run = 1; steps(238);
    check("snooze_before_end", ringing, 0);
    step();
    check("snooze_rering", ringing, 1);
    check("snooze_rering_min", minutes_out, 31);
    check("snooze_rering_sec", seconds_out, 0);
    steps(5);
    run = 0; steps(50);
    check("ring_frozen", ringing, 1);
    run = 1; steps(6);
    check("timeout_before", ringing, 1);
    step();
    check("timeout_after", ringing, 0);
    run = 0;

    // stop and snooze together: stop wins, no later re-ring
    ring_up();
    stop = 1; snooze = 1; step(); stop = 0; snooze = 0;
    check("stop_snooze_ringing", ringing, 0);
    begin
      int seen = 0;
      repeat (260) begin
        step();
        if (ringing) seen = 1;
      end
      check("stop_snooze_no_rering", seen, 0);
    end
    run = 0;

    // alarm_en dropped during snooze: never rings again
    ring_up();
    snooze = 1; step(); snooze = 0;
    alarm_en = 0; step(); alarm_en = 1;
    begin
      int seen = 0;
      repeat (260) begin
        step();
        if (ringing) seen = 1;
      end
      check("en_drop_no_ring", seen, 0);
    end
    run = 0;

    // Asynchronous reset mid-ring
    ring_up();
    #1 reset_n = 0;
    #1 check("async_reset_ringing", ringing, 0);
    check("async_reset_min", minutes_out, 0);
    step();
    reset_n = 1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
